// File: rtl/sa_req_sched.sv
// Request scheduler for the sa successive-approximation core: queues y_t targets,
// issues them one at a time and returns x/y results with signed error and timeout flag.
module sa_req_sched #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned TIMEOUT    = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [9:0]  in_y_t,
    output logic [9:0]  sa_y_t,
    output logic        sa_start,
    input  logic        sa_done,
    input  logic [3:0]  sa_x,
    input  logic [9:0]  sa_y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_x,
    output logic [9:0]  out_y,
    output logic [10:0] out_diff,
    output logic        out_tmo,
    output logic        busy
);

    localparam int unsigned Y_W   = 10;
    localparam int unsigned X_W   = 4;
    localparam int unsigned D_W   = 11;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SET_W = $clog2(SETUP_CYC + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_OUT   = 3'd4;

    logic [2:0]       state;
    logic [2:0]       state_d;
    logic [Y_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_d;
    logic [SET_W-1:0] setup_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic             push;
    logic             pop;
    logic             done_q;
    logic             done_rise;
    logic             setup_ok;
    logic             tmo_hit;

    // Fullness comes from the registered count only, so a full FIFO never accepts
    assign in_ready  = (count != CNT_W'(FIFO_DEPTH));
    assign push      = in_valid & in_ready;
    assign pop       = (state == S_IDLE) && (count != '0);
    assign done_rise = sa_done & ~done_q;
    assign setup_ok  = (setup_cnt == SET_W'(SETUP_CYC - 1));
    assign tmo_hit   = (tmo_cnt == TMO_W'(TIMEOUT - 1));

    // Occupancy after this cycle's push/pop
    always_comb begin
        count_d = count;
        if (push && !pop) begin
            count_d = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count - CNT_W'(1);
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (pop) state_d = S_SETUP;
            S_SETUP: if (setup_ok && !sa_done) state_d = S_START;
            S_START: state_d = S_WAIT;
            S_WAIT:  if (done_rise || tmo_hit) state_d = S_OUT;
            S_OUT:   if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // FIFO storage, no reset needed: entries are only read after being written
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_y_t;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_d;
        end
    end

    // Sequencing counters and edge detect on sa_done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q    <= 1'b0;
            setup_cnt <= '0;
            tmo_cnt   <= '0;
        end else begin
            done_q <= sa_done;
            if (pop) begin
                setup_cnt <= '0;
            end else if ((state == S_SETUP) && !setup_ok) begin
                setup_cnt <= setup_cnt + SET_W'(1);
            end
            if (state == S_START) begin
                tmo_cnt <= '0;
            end else if ((state == S_WAIT) && !done_rise && !tmo_hit) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
        end
    end

    // Registered outputs toward sa and the result port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_y_t    <= '0;
            sa_start  <= 1'b0;
            out_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            out_diff  <= '0;
            out_tmo   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            sa_start  <= (state_d == S_START);
            out_valid <= (state_d == S_OUT);
            busy      <= (state_d != S_IDLE) || (count_d != '0);
            if (pop) begin
                sa_y_t <= mem[rd_ptr];
            end
            if (state == S_WAIT) begin
                if (done_rise) begin
                    out_x    <= sa_x;
                    out_y    <= sa_y;
                    out_diff <= {1'b0, sa_y} - {1'b0, sa_y_t};
                    out_tmo  <= 1'b0;
                end else if (tmo_hit) begin
                    out_x    <= X_W'(0);
                    out_y    <= Y_W'(0);
                    out_diff <= D_W'(0);
                    out_tmo  <= 1'b1;
                end
            end
        end
    end

endmodule
